// File: rtl/edge_pipe_sched_pkg.sv
// Shared types and defaults for the round-robin edge-detect scheduler.
package edge_pipe_sched_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

   localparam int NREQ_DEF     = 4;
   localparam int W_DEF        = 8;
   localparam int PIPE_LAT_DEF = 2;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/edge_pipe.sv
// Serial transition detector: dout = din ^ previous din, two clocks after din.
module edge_pipe (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic din,
   output logic dout
);

   logic cur_p0;
   logic hist_p0;
   logic xor_p1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_p0  <= 1'b0;
         hist_p0 <= 1'b0;
         xor_p1  <= 1'b0;
      end else begin
         // p0: capture bit and its predecessor (zeroed at the start of a word)
         cur_p0  <= din;
         hist_p0 <= flush ? 1'b0 : cur_p0;
         // p1: registered transition bit
         xor_p1  <= cur_p0 ^ hist_p0;
      end
   end

   assign dout = xor_p1;

endmodule

// File: rtl/edge_pipe_sched.sv
// Round-robin scheduler sharing one edge_pipe among NREQ requesters, one job at a time.
module edge_pipe_sched
   import edge_pipe_sched_pkg::*;
#(
   parameter int NREQ     = NREQ_DEF,
   parameter int W        = W_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*W-1:0]        req_data,
   output logic [NREQ-1:0]          gnt,
   output logic                     busy,
   output logic                     resp_valid,
   output logic [clog2(NREQ)-1:0]   resp_id,
   output logic [W-1:0]             resp_data
);

   localparam int IDW   = clog2(NREQ);
   localparam int CNT_W = clog2((W > PIPE_LAT) ? W : PIPE_LAT) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(W - 1);
   localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(PIPE_LAT - 1);
   localparam logic [CNT_W-1:0] LAT_C      = CNT_W'(PIPE_LAT);

   state_t            state, state_n;
   logic [IDW-1:0]    rr_ptr, pick, arb_idx, job_id;
   logic              found;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [NREQ-1:0]   gnt_c;
   logic [W-1:0]      shreg;
   logic [W-2:0]      col;
   logic [W-1:0]      col_ext;
   logic              feed, flush, collect, last_drain, pipe_out;

   // first requesting lane after the last one served
   always_comb begin
      found   = 1'b0;
      pick    = '0;
      arb_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         arb_idx = IDW'((int'(rr_ptr) + k) % NREQ);
         if (!found && req[arb_idx]) begin
            found = 1'b1;
            pick  = arb_idx;
         end
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      gnt_c      = '0;
      feed       = 1'b0;
      flush      = 1'b0;
      collect    = 1'b0;
      last_drain = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               gnt_c   = NREQ'(1) << pick;
               cnt_n   = '0;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            feed    = 1'b1;
            flush   = (cnt == '0);
            collect = (cnt >= LAT_C);
            if (cnt == LAST_BIT) begin
               cnt_n   = '0;
               state_n = DRAIN;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DRAIN: begin
            collect = 1'b1;
            if (cnt == LAST_DRAIN) begin
               last_drain = 1'b1;
               cnt_n      = '0;
               state_n    = DONE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         rr_ptr    <= IDW'(NREQ - 1);
         resp_id   <= '0;
         resp_data <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (state == IDLE && found) rr_ptr <= pick;
         if (last_drain) begin
            resp_id   <= job_id;
            resp_data <= col_ext;
         end
      end
   end

   // collector fills from the top so the first result bit ends at position 0
   assign col_ext = {pipe_out, col};

   always_ff @(posedge clk) begin
      if (state == IDLE && found) begin
         shreg  <= req_data[pick*W +: W];
         job_id <= pick;
      end else if (feed) begin
         shreg <= {1'b0, shreg[W-1:1]};
      end
      if (collect) col <= col_ext[W-1:1];
   end

   edge_pipe u_pipe (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .din   (shreg[0]),
      .dout  (pipe_out)
   );

   // gnt is combinational from req, so hold it low while reset is asserted
   assign gnt        = gnt_c & {NREQ{rst}};
   assign busy       = (state != IDLE);
   assign resp_valid = (state == DONE);

endmodule

// File: tb/tb_edge_pipe_sched.sv
// Scoreboard bench for edge_pipe_sched: directed jobs, monitor checks id, data and latency.
`timescale 1ns/1ps
module tb_edge_pipe_sched;

   localparam int W   = 8;
   localparam int LAT = 11;

   typedef struct {
      int          id;
      logic [7:0]  d;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        busy;
   logic        resp_valid;
   logic [1:0]  resp_id;
   logic [7:0]  resp_data;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [7:0]  rr_exp [4] = '{8'hFE, 8'h01, 8'h11, 8'h44};
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;

   edge_pipe_sched #(.NREQ(4), .W(W), .PIPE_LAT(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_data   (req_data),
      .gnt        (gnt),
      .busy       (busy),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_data  (resp_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
      end
   endtask

   // monitor: every response must match the oldest expectation
   always @(negedge clk) begin
      if (rst === 1'b1 && resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_resp: id %0d data %0h, no response expected", resp_id, resp_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp_id", resp_id, mon_e.id);
            chk("resp_data", resp_data, mon_e.d);
            chk("resp_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic wait_gnt(output logic [3:0] g, output int t);
      bit got;
      got = 1'b0;
      g = '0;
      t = -1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (gnt !== 4'b0) begin
            g   = gnt;
            t   = cyc;
            got = 1'b1;
         end
      end
      if (!got) begin
         n_chk++;
         n_fail++;
         $display("FAIL gnt_timeout: no gnt within 40 cycles, expected one");
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && busy === 1'b0) ok = 1'b1;
      end
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout: %0d responses outstanding, expected 0", exp_q.size());
      end
   endtask

   task automatic issue(input int lane, input logic [7:0] data, input logic [7:0] expd);
      logic [3:0] g;
      int t;
      @(posedge clk); #1;
      req_data[lane*8 +: 8] = data;
      req = 4'b1 << lane;
      wait_gnt(g, t);
      chk("gnt_lane", g, 32'(1) << lane);
      if (t >= 0) exp_q.push_back('{lane, expd, t + LAT});
      @(posedge clk); #1;
      req = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] g;
      int t, tprev;
      rst      = 1'b0;
      req      = 4'hF;
      req_data = 32'h3C0FFFAA;
      repeat (3) @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_data", resp_data, 0);
      @(posedge clk); #1;
      req = '0;
      rst = 1'b1;

      issue(2, 8'hAA, 8'hFE); wait_idle();
      issue(0, 8'hFF, 8'h01); wait_idle();
      issue(0, 8'h00, 8'h00); wait_idle();
      issue(0, 8'h0F, 8'h11); wait_idle();

      // all lanes requesting from reset: rotation 0,1,2,3,0 every 12 cycles
      @(posedge clk); #1;
      rst      = 1'b0;
      req      = 4'hF;
      req_data = 32'h3C0FFFAA;
      @(posedge clk); #1;
      rst   = 1'b1;
      tprev = 0;
      for (int i = 0; i < 5; i++) begin
         wait_gnt(g, t);
         chk("rr_gnt", g, 32'(1) << (i % 4));
         if (i > 0) chk("rr_period", t - tprev, 12);
         if (t >= 0) exp_q.push_back('{i % 4, rr_exp[i % 4], t + LAT});
         tprev = t;
         @(posedge clk); #1;
         if (i == 4) req = '0;
      end
      wait_idle();

      // lane 1 requests while lane 3 is in flight; lane 3 data edited after gnt
      @(posedge clk); #1;
      req_data[31:24] = 8'h3C;
      req = 4'b1000;
      wait_gnt(g, t);
      chk("mid_gnt3", g, 4'b1000);
      if (t >= 0) exp_q.push_back('{3, 8'h44, t + LAT});
      tprev = t;
      @(posedge clk); #1;
      req = 4'b0010;
      req_data[31:24] = 8'hFF;
      req_data[15:8]  = 8'h0F;
      wait_gnt(g, t);
      chk("mid_gnt1", g, 4'b0010);
      chk("mid_gnt1_delay", t - tprev, 12);
      if (t >= 0) exp_q.push_back('{1, 8'h11, t + LAT});
      @(posedge clk); #1;
      req = '0;
      wait_idle();

      // reset during SHIFT of lane 0: job dropped, pointer back to lane 3
      @(posedge clk); #1;
      req_data[7:0] = 8'hAA;
      req = 4'b0001;
      wait_gnt(g, t);
      chk("rstjob_gnt", g, 4'b0001);
      @(posedge clk); #1;
      req = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_gnt", gnt, 0);
      chk("midrst_resp_valid", resp_valid, 0);
      chk("midrst_resp_id", resp_id, 0);
      chk("midrst_resp_data", resp_data, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      req_data[15:8] = 8'hFF;
      req = 4'h3;
      wait_gnt(g, t);
      chk("postrst_gnt", g, 4'b0001);
      if (t >= 0) exp_q.push_back('{0, 8'hFE, t + LAT});
      @(posedge clk); #1;
      req = '0;
      wait_idle();
      chk("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
